regbank_mem_scoreboard: RTL and testbench

Parametrised successor of the 8x8 register bank. It holds NREGS registers of WIDTH bits. One write port takes its data from a 4-way source mux (ALU, REG, IMM, MEM). It has two read ports. Memory-sourced writes complete later via a valid pulse, and a per-register busy scoreboard tracks them. It sits between the decoder/ALU datapath and the memory interface of the C0 core.

---
 rtl/regbank_mem_scoreboard.sv | 142 ++++++++++++++
 tb/tb_regbank_mem_scoreboard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regbank_mem_scoreboard.sv
// rtl/regbank_mem_scoreboard.sv - register bank with 4-way write mux and one-deep memory-load scoreboard
//
// Purpose: NREGS x WIDTH register bank with one write port and two combinational
// read ports. A write with MS=3 does not write data at once. It records a pending
// load and sets BUSY for the destination. A later MEM_VALID pulse completes the load.
// Only one load can be outstanding at a time. A further load request stalls until
// the outstanding load returns.
// State changes on the falling edge of CLK.
//
// Optional feature: define REGBANK_BYPASS_EN to forward the data written this
// cycle onto RA/RB when the read select matches the landing register.
//
// Ports:
//   CLK, RST            clock (falling-edge) and synchronous active-high reset
//   E, WSEL, MS         write request: enable, destination, source select (0 ALU, 1 REG, 2 IMM, 3 MEM)
//   ALU, REG, IMM       direct write sources
//   MEM_DATA, MEM_VALID memory return data and its one-cycle qualifier
//   RA_SEL/RA, RB_SEL/RB combinational read ports
//   BUSY                per-register pending-load bits
//   MEM_PEND            a load is outstanding (including a cancelled one)
//   STALL               the current MS=3 request cannot be accepted
module regbank_mem_scoreboard #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int SELW  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             E,
  input  logic [SELW-1:0]  WSEL,
  input  logic [1:0]       MS,
  input  logic [WIDTH-1:0] ALU,
  input  logic [WIDTH-1:0] REG,
  input  logic [WIDTH-1:0] IMM,
  input  logic [WIDTH-1:0] MEM_DATA,
  input  logic             MEM_VALID,
  input  logic [SELW-1:0]  RA_SEL,
  output logic [WIDTH-1:0] RA,
  input  logic [SELW-1:0]  RB_SEL,
  output logic [WIDTH-1:0] RB,
  output logic [NREGS-1:0] BUSY,
  output logic             MEM_PEND,
  output logic             STALL
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             mem_pend_q, mem_pend_d;
  logic [SELW-1:0]  pend_dest_q, pend_dest_d;
  // The outstanding load was overtaken by a direct write, so its data must be dropped.
  logic             cancel_q, cancel_d;

  logic             direct_wr;
  logic             mem_ret;
  logic             mem_land;
  logic             new_req;
  logic [WIDTH-1:0] src_data;

  always_comb begin
    src_data = IMM;
    case (MS)
      2'd0:    src_data = ALU;
      2'd1:    src_data = REG;
      default: src_data = IMM;
    endcase
  end

  // Direct writes never stall; only a second load request can stall.
  assign STALL     = E & (MS == 2'd3) & mem_pend_q & ~MEM_VALID;
  assign direct_wr = E & (MS != 2'd3);
  assign mem_ret   = MEM_VALID & mem_pend_q;
  // A same-edge direct write to the load's destination is younger, so it wins.
  assign mem_land  = mem_ret & ~cancel_q & ~(direct_wr & (WSEL == pend_dest_q));
  // A load request accepted on the same edge as the return allows back-to-back loads.
  assign new_req   = E & (MS == 2'd3) & ~STALL;

  always_comb begin
    regs_d      = regs_q;
    busy_d      = busy_q;
    mem_pend_d  = mem_pend_q;
    pend_dest_d = pend_dest_q;
    cancel_d    = cancel_q;

    if (mem_ret) begin
      if (mem_land) regs_d[pend_dest_q] = MEM_DATA;
      busy_d[pend_dest_q] = 1'b0;
      mem_pend_d          = 1'b0;
      cancel_d            = 1'b0;
    end else if (direct_wr && mem_pend_q && (WSEL == pend_dest_q)) begin
      cancel_d = 1'b1;
    end

    if (direct_wr) begin
      regs_d[WSEL] = src_data;
      busy_d[WSEL] = 1'b0;
    end

    if (new_req) begin
      busy_d[WSEL] = 1'b1;
      mem_pend_d   = 1'b1;
      pend_dest_d  = WSEL;
      cancel_d     = 1'b0;
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q      <= '0;
      mem_pend_q  <= 1'b0;
      pend_dest_q <= '0;
      cancel_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      mem_pend_q  <= mem_pend_d;
      pend_dest_q <= pend_dest_d;
      cancel_q    <= cancel_d;
    end
  end

  assign BUSY     = busy_q;
  assign MEM_PEND = mem_pend_q;

`ifdef REGBANK_BYPASS_EN
  always_comb begin
    RA = regs_q[RA_SEL];
    if (direct_wr && (WSEL == RA_SEL))           RA = src_data;
    else if (mem_land && (pend_dest_q == RA_SEL)) RA = MEM_DATA;
    RB = regs_q[RB_SEL];
    if (direct_wr && (WSEL == RB_SEL))           RB = src_data;
    else if (mem_land && (pend_dest_q == RB_SEL)) RB = MEM_DATA;
  end
`else
  always_comb begin
    RA = regs_q[RA_SEL];
    RB = regs_q[RB_SEL];
  end
`endif

endmodule

// File: tb/tb_regbank_mem_scoreboard.sv
// tb/tb_regbank_mem_scoreboard.sv - scoreboard bench for regbank_mem_scoreboard
module tb_regbank_mem_scoreboard;

  logic       CLK = 1'b1;
  logic       RST = 1'b0, E = 1'b0, MEM_VALID = 1'b0;
  logic [2:0] WSEL = '0, RA_SEL = '0, RB_SEL = '0;
  logic [1:0] MS = '0;
  logic [7:0] ALU = '0, REG = '0, IMM = '0, MEM_DATA = '0;
  logic [7:0] RA, RB, BUSY;
  logic       MEM_PEND, STALL;

  regbank_mem_scoreboard #(.WIDTH(8), .NREGS(8), .SELW(3)) dut (
    .CLK(CLK), .RST(RST), .E(E), .WSEL(WSEL), .MS(MS),
    .ALU(ALU), .REG(REG), .IMM(IMM), .MEM_DATA(MEM_DATA), .MEM_VALID(MEM_VALID),
    .RA_SEL(RA_SEL), .RA(RA), .RB_SEL(RB_SEL), .RB(RB),
    .BUSY(BUSY), .MEM_PEND(MEM_PEND), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         chk;
    logic [7:0] ra, rb, busy;
    logic       pend, stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: register contents plus a list of outstanding loads
  // (at most one), each remembering whether its data will still land.
  int  m_regs[8];
  bit  known = 0;
  int  load_dest[$];
  bit  load_live[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int src_of(input int ms, input int alu, input int rg, input int imm);
    if (ms == 0) return alu;
    if (ms == 1) return rg;
    return imm;
  endfunction

  // Drive one request cycle, predict what the DUT shows before the coming
  // falling edge, then apply that edge's effect to the model.
  task automatic step(input bit rst, input bit e, input int wsel, input int ms,
                      input int alu, input int rg, input int imm, input int md,
                      input bit mv, input int ra, input int rb);
    exp_t x;
    bit   direct, pending, stall, lands;
    int   src, dest;
    @(negedge CLK); #1;
    RST = rst; E = e; WSEL = 3'(wsel); MS = 2'(ms);
    ALU = 8'(alu); REG = 8'(rg); IMM = 8'(imm); MEM_DATA = 8'(md);
    MEM_VALID = mv; RA_SEL = 3'(ra); RB_SEL = 3'(rb);

    direct  = e && (ms != 3);
    src     = src_of(ms, alu, rg, imm) & 255;
    pending = load_dest.size() > 0;
    dest    = pending ? load_dest[0] : 0;
    stall   = e && (ms == 3) && pending && !mv;
    lands   = mv && pending && load_live[0] && !(direct && wsel == dest);

    x.chk   = known;
    x.stall = stall;
    x.pend  = pending;
    x.busy  = (pending && load_live[0]) ? 8'(1 << dest) : 8'h00;
    x.ra    = 8'(m_regs[ra]);
    x.rb    = 8'(m_regs[rb]);
`ifdef REGBANK_BYPASS_EN
    if (direct && wsel == ra) x.ra = 8'(src);
    else if (lands && dest == ra) x.ra = 8'(md);
    if (direct && wsel == rb) x.rb = 8'(src);
    else if (lands && dest == rb) x.rb = 8'(md);
`endif
    exp_q.push_back(x);

    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      load_dest.delete();
      load_live.delete();
      known = 1;
    end else begin
      if (mv && pending) begin
        if (lands) m_regs[dest] = md & 255;
        void'(load_dest.pop_front());
        void'(load_live.pop_front());
      end else if (direct && pending && wsel == dest) begin
        load_live[0] = 0;
      end
      if (direct) m_regs[wsel] = src;
      if (e && ms == 3 && !stall) begin
        load_dest.push_back(wsel);
        load_live.push_back(1);
      end
    end
  endtask

  task automatic idle_read(input int ra, input int rb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  // Monitor: the DUT presents a settled output each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.chk) begin
          cmp("RA", RA, x.ra);
          cmp("RB", RB, x.rb);
          cmp("BUSY", BUSY, x.busy);
          cmp("MEM_PEND", MEM_PEND, x.pend);
          cmp("STALL", STALL, x.stall);
        end
      end
    end
  end

  initial begin
    // 1: reset for two edges, then read every register
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_read(i, i + 4);
    // 2: IMM write to R5
    step(0, 1, 5, 2, 8'h11, 8'h22, 8'h7B, 0, 0, 5, 4);
    idle_read(5, 4);
    // 3: load R3, stalled second load, return
    step(0, 1, 3, 3, 0, 0, 0, 0, 0, 3, 5);
    step(0, 1, 6, 3, 0, 0, 0, 0, 0, 3, 6);
    step(0, 0, 0, 0, 0, 0, 0, 8'hA5, 1, 3, 6);
    idle_read(3, 6);
    // 4: load R2 overtaken by an ALU write, then stale return
    step(0, 1, 2, 3, 0, 0, 0, 0, 0, 2, 0);
    step(0, 1, 2, 0, 8'h11, 0, 0, 0, 0, 2, 0);
    idle_read(2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 8'hEE, 1, 2, 0);
    idle_read(2, 0);
    // 5: return to R1 on the same edge as a new load to R6
    step(0, 1, 1, 3, 0, 0, 0, 0, 0, 1, 6);
    step(0, 1, 6, 3, 0, 0, 0, 8'h42, 1, 1, 6);
    idle_read(1, 6);
    // same-edge direct write and return to the same register
    step(0, 1, 6, 1, 0, 8'h5C, 0, 8'h99, 1, 6, 1);
    idle_read(6, 1);
    // stray MEM_VALID with nothing pending
    step(0, 0, 0, 0, 0, 0, 0, 8'h33, 1, 0, 1);
    // 6: reset with a load pending, then a late return
    step(0, 1, 4, 3, 0, 0, 0, 0, 0, 4, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5);
    step(0, 0, 0, 0, 0, 0, 0, 8'h77, 1, 4, 5);
    for (int i = 0; i < 4; i++) idle_read(i, i + 4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 7), $urandom_range(0, 7));
    end
    idle_read(0, 1);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
